i2s_transmitter: RTL and testbench

Output end of the effects sample path. Accepts processed 16-bit stereo samples from the last effect stage (distortion/delay chain) over a valid/ready handshake, double-buffers them, and serialises them to the codec DAC as standard I2S (MSB first, one-bit WS delay). The block generates the bit clock and word select itself, so the chain is paced by `sample_ready`.

---
 rtl/i2s_transmitter.sv | 111 +++++++++++
 tb/tb_i2s_transmitter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S transmitter: double-buffered stereo sample input over valid/ready,
// serialised MSB first with one-bit WS delay; generates bclk and lrclk.
// Ports: clk, reset (async active-low), sample_left/right, sample_valid,
//        sample_ready, bclk, lrclk, sdata, underrun (one-clk pulse).
`timescale 1ns/1ps
module i2s_transmitter #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SCLK_DIV     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun
);
    localparam int W  = SAMPLE_WIDTH;
    localparam int BW = $clog2(2 * W);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(2 * W - 1);
    localparam logic [BW-1:0] LR_LO    = BW'(W - 1);
    localparam logic [BW-1:0] LR_HI    = BW'(2 * W - 2);

    logic [DW-1:0]  div_q, div_d;
    logic           bclk_q, bclk_d;
    // b_q is the slot entered at the next falling edge.
    logic [BW-1:0]  b_q, b_d;
    logic [2*W-1:0] shift_q, shift_d;
    logic [W-1:0]   hold_l_q, hold_l_d;
    logic [W-1:0]   hold_r_q, hold_r_d;
    logic           pending_q, pending_d;
    logic           lr_q, lr_d;
    logic           sdata_q, sdata_d;
    logic           urun_q, urun_d;

    logic           wrap, fe, fstart, accept;
    logic [2*W-1:0] load, src;

    assign wrap   = (div_q == DIV_LAST);
    assign fe     = wrap && bclk_q;
    assign fstart = fe && (b_q == '0);
    assign accept = sample_valid && !pending_q;
    assign load   = pending_q ? {hold_l_q, hold_r_q} : '0;
    // Frame start sends the freshly loaded word's MSB in the same edge.
    assign src    = fstart ? load : shift_q;

    always_comb begin
        div_d     = wrap ? '0 : div_q + 1'b1;
        bclk_d    = wrap ? !bclk_q : bclk_q;
        b_d       = b_q;
        shift_d   = shift_q;
        lr_d      = lr_q;
        sdata_d   = sdata_q;
        urun_d    = fstart && !pending_q;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        pending_d = pending_q;
        if (fe) begin
            sdata_d = src[2*W-1];
            shift_d = src << 1;
            lr_d    = (b_q >= LR_LO) && (b_q <= LR_HI);
            b_d     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
        end
        // accept only happens with pending clear, so it wins over the clear
        if (accept) begin
            hold_l_d  = sample_left;
            hold_r_d  = sample_right;
            pending_d = 1'b1;
        end else if (fstart) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            b_q       <= '0;
            shift_q   <= '0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            pending_q <= 1'b0;
            lr_q      <= 1'b0;
            sdata_q   <= 1'b0;
            urun_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            b_q       <= b_d;
            shift_q   <= shift_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            pending_q <= pending_d;
            lr_q      <= lr_d;
            sdata_q   <= sdata_d;
            urun_q    <= urun_d;
        end
    end

    assign sample_ready = !pending_q;
    assign bclk         = bclk_q;
    assign lrclk        = lr_q;
    assign sdata        = sdata_q;
    assign underrun     = urun_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed testbench for i2s_transmitter (W=16, SCLK_DIV=2).
// Bit = 4 clk, frame = 128 clk, frame f starts at cycle 4 + 128*f.
`timescale 1ns/1ps
module tb_i2s_transmitter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_left = '0;
    logic [15:0] sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, bclk, lrclk, sdata, underrun;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int urn_cnt = 0;

    localparam logic [31:0] WS_EXP = 32'h7FFF_8000;

    i2s_transmitter #(.SAMPLE_WIDTH(16), .SCLK_DIV(2)) dut (
        .clk(clk), .reset(reset),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
        if (underrun) urn_cnt <= urn_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        sample_valid = 1'b1;
        sample_left = l;
        sample_right = r;
        while (!sample_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL push_timeout got ready=%b exp 1", sample_ready);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic get_frame(input int f, output logic [15:0] l,
                             output logic [15:0] r, output logic [31:0] ws,
                             output logic u0, output int stab);
        int base;
        logic d, w;
        base = 4 + 128 * f;
        stab = 0;
        u0 = 1'b0;
        for (int s = 0; s < 32; s++) begin
            goto(base + 4 * s);
            d = sdata;
            w = lrclk;
            if (s == 0) u0 = underrun;
            if (s < 16) l[15-s] = d;
            else        r[31-s] = d;
            ws[s] = w;
            goto(base + 4 * s + 2);
            if (bclk !== 1'b1 || sdata !== d || lrclk !== w) stab++;
        end
    endtask

    task automatic test_reset();
        logic [15:0] l, r;
        do_reset();
        push(16'hAAAA, 16'h5555);
        goto(10);
        push(16'h1357, 16'h2468);
        goto(60);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_outputs got %b exp 00001",
                     {bclk, lrclk, sdata, underrun, sample_ready});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        goto(1);
        tests++;
        if (bclk !== 1'b0) begin
            fails++; $display("FAIL bclk_c1 got %b exp 0", bclk);
        end
        goto(2);
        tests++;
        if (bclk !== 1'b1) begin
            fails++; $display("FAIL bclk_rise_c2 got %b exp 1", bclk);
        end
        goto(4);
        tests++;
        if (bclk !== 1'b0 || underrun !== 1'b1) begin
            fails++;
            $display("FAIL first_fe_c4 got bclk=%b urun=%b exp 0 1",
                     bclk, underrun);
        end
        goto(5);
        tests++;
        if (underrun !== 1'b0) begin
            fails++; $display("FAIL urun_pulse_c5 got %b exp 0", underrun);
        end
    endtask

    task automatic test_single();
        logic [15:0] l, r;
        logic [31:0] ws;
        logic u0;
        int st, u;
        do_reset();
        u = urn_cnt;
        push(16'h8001, 16'h7FFE);
        get_frame(0, l, r, ws, u0, st);
        tests++;
        if ({l, r} !== 32'h8001_7FFE) begin
            fails++; $display("FAIL single_data got %h exp 80017ffe", {l, r});
        end
        tests++;
        if (ws !== WS_EXP) begin
            fails++; $display("FAIL single_ws got %h exp %h", ws, WS_EXP);
        end
        tests++;
        if (urn_cnt - u !== 0) begin
            fails++; $display("FAIL single_urun got %0d exp 0", urn_cnt - u);
        end
        tests++;
        if (st !== 0) begin
            fails++; $display("FAIL single_stable got %0d exp 0", st);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] l, r;
        logic [31:0] ws;
        logic u0;
        int st, u, acc;
        logic [15:0] n;
        do_reset();
        u = urn_cnt;
        acc = 0;
        n = 16'h0100;
        fork
            begin
                logic rw;
                sample_valid = 1'b1;
                sample_left = n;
                sample_right = n;
                repeat (512) begin
                    rw = sample_ready;
                    @(negedge clk);
                    if (rw) begin
                        acc++;
                        n = n + 1'b1;
                        sample_left = n;
                        sample_right = n;
                    end
                end
                sample_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 4; f++) begin
                    get_frame(f, l, r, ws, u0, st);
                    tests++;
                    if (l !== 16'h0100 + 16'(f) || r !== 16'h0100 + 16'(f)) begin
                        fails++;
                        $display("FAIL b2b_frame%0d got %h/%h exp %h", f, l, r,
                                 16'h0100 + 16'(f));
                    end
                end
            end
        join
        tests++;
        if (acc !== 5) begin
            fails++; $display("FAIL b2b_accepts got %0d exp 5", acc);
        end
        tests++;
        if (urn_cnt - u !== 0) begin
            fails++; $display("FAIL b2b_urun got %0d exp 0", urn_cnt - u);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] l, r;
        logic [31:0] ws;
        logic u0;
        int st, u;
        do_reset();
        u = urn_cnt;
        push(16'hA5A5, 16'h5A5A);
        get_frame(0, l, r, ws, u0, st);
        tests++;
        if ({l, r} !== 32'hA5A5_5A5A) begin
            fails++; $display("FAIL urun_frame0 got %h exp a5a55a5a", {l, r});
        end
        get_frame(1, l, r, ws, u0, st);
        tests++;
        if ({l, r} !== 32'h0 || u0 !== 1'b1) begin
            fails++;
            $display("FAIL urun_frame1 got %h u0=%b exp 0 u0=1", {l, r}, u0);
        end
        tests++;
        if (urn_cnt - u !== 1) begin
            fails++; $display("FAIL urun_count got %0d exp 1", urn_cnt - u);
        end
    endtask

    task automatic test_simul_accept();
        logic [15:0] l, r;
        logic [31:0] ws;
        logic u0;
        int st;
        do_reset();
        goto(3);
        sample_valid = 1'b1;
        sample_left = 16'h1234;
        sample_right = 16'h5678;
        goto(4);
        sample_valid = 1'b0;
        tests++;
        if (sample_ready !== 1'b0) begin
            fails++; $display("FAIL simul_ready_c4 got %b exp 0", sample_ready);
        end
        get_frame(0, l, r, ws, u0, st);
        tests++;
        if ({l, r} !== 32'h0 || u0 !== 1'b1) begin
            fails++;
            $display("FAIL simul_frame0 got %h u0=%b exp 0 u0=1", {l, r}, u0);
        end
        tests++;
        if (sample_ready !== 1'b0) begin
            fails++; $display("FAIL simul_ready_mid got %b exp 0", sample_ready);
        end
        get_frame(1, l, r, ws, u0, st);
        tests++;
        if ({l, r} !== 32'h1234_5678 || u0 !== 1'b0) begin
            fails++;
            $display("FAIL simul_frame1 got %h u0=%b exp 12345678 u0=0",
                     {l, r}, u0);
        end
        tests++;
        if (sample_ready !== 1'b1) begin
            fails++; $display("FAIL simul_ready_end got %b exp 1", sample_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] l, r;
        logic [31:0] ws;
        logic u0;
        int st, u;
        do_reset();
        u = urn_cnt;
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        fork
            begin
                goto(6);
                sample_valid = 1'b1;
                sample_left = 16'hDEAD;
                sample_right = 16'hBEEF;
                goto(50);
                sample_left = 16'hCAFE;
                sample_right = 16'hF00D;
                goto(131);
                sample_left = 16'h0BAD;
                sample_right = 16'hFACE;
                goto(132);
                tests++;
                if (sample_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_ready_c132 got %b exp 1", sample_ready);
                end
                sample_left = 16'h600D;
                sample_right = 16'h0001;
                goto(133);
                sample_valid = 1'b0;
                tests++;
                if (sample_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_ready_c133 got %b exp 0", sample_ready);
                end
            end
            begin
                get_frame(1, l, r, ws, u0, st);
                tests++;
                if ({l, r} !== 32'h3333_4444) begin
                    fails++;
                    $display("FAIL bp_frame1 got %h exp 33334444", {l, r});
                end
                get_frame(2, l, r, ws, u0, st);
                tests++;
                if ({l, r} !== 32'h600D_0001) begin
                    fails++;
                    $display("FAIL bp_frame2 got %h exp 600d0001", {l, r});
                end
            end
        join
        tests++;
        if (urn_cnt - u !== 0) begin
            fails++; $display("FAIL bp_urun got %0d exp 0", urn_cnt - u);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_simul_accept();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
